seg_scan_ctrl: RTL and testbench
================================

// Module: seg_scan_ctrl
// PURPOSE
// - Scan controller for the 8-digit multiplexed 7-seg display (Nexys4 DDR, common anode).
// - Owns digit sequencing, anti-ghost guard, 16-level PWM brightness, per-digit enable, leading-zero blanking.
// - Holds a double-buffered frame: producers write a shadow copy, which swaps in only at a frame boundary.
// - Sits between the value producer and the an/seg/dp board pins.
// PARAMETERS
// CLK_HZ      100_000_000  input clock frequency
// REFRESH_HZ  1000         digit-slot rate; DIV = CLK_HZ/REFRESH_HZ cycles per slot
// GUARD_CYC   1000         cycles at slot start with all anodes off; require DIV >= GUARD_CYC+16
// PORTS
// clk         in   1   system clock
// rst_n       in   1   asynchronous, active-low reset
// wr_valid    in   1   frame write request
// wr_ready    out  1   shadow buffer free; write accepted when wr_valid & wr_ready
// wr_digits   in   32  nibble i = digit i; digit 0 is rightmost (an[0])
// wr_dp       in   8   bit i = decimal point of digit i (1 = lit)
// wr_mask     in   8   bit i = digit i enabled (0 = blanked)
// wr_lz       in   1   leading-zero blanking enable for this frame
// brightness  in   4   0 = dark, 15 = max; sampled at each slot start
// an          out  8   anode enables, active-low
// seg         out  7   {g,f,e,d,c,b,a}, active-low
// dp          out  1   decimal point, active-low
// frame_done  out  1   1-cycle pulse at end of each digit-7 slot
// BEHAVIOUR
// - Reset: an=8'hFF, seg=7'h7F, dp=1, frame_done=0, wr_ready=1; active and shadow buffers zeroed (mask=0); digit=0, slot_cnt=0.
// - Reset asserted mid-frame blanks outputs immediately (async); scan restarts at digit 0, slot_cnt 0 after release.
// - Slot: slot_cnt runs 0..DIV-1, then wraps and digit advances 7->0 (3-bit wrap).
// - STEP = (DIV-GUARD_CYC)/16 (integer). on_cyc = brightness_latched*STEP.
// - Slot FSM: GUARD (slot_cnt < GUARD_CYC) -> ON (next on_cyc cycles) -> OFF (rest of slot) -> GUARD of next digit.
// - on_cyc = 0 skips ON entirely. Anode for digit d is low only in ON and only when mask[d]=1 and the digit is not LZ-blanked.
// - LZ: if lz=1, digits 7 downward whose nibble is 0 are blanked up to the first nonzero digit. Digit 0 is never LZ-blanked. A digit's dp bit does not stop blanking.
// - seg = hex code of nibble (0-F) while anode is on, else 7'h7F. dp = ~dp_bit while anode is on, else 1.
// - an/seg/dp are registered: 1-cycle latency from internal state; no combinational path from inputs to pins.
// - Handshake: accepted write loads shadow and sets pending; wr_ready = ~pending.
// - At end of digit-7 slot: if pending, active<=shadow and pending<=0 (wr_ready rises next cycle); frame_done pulses regardless.
// - Write accepted on the same cycle as the frame-end swap (pending was 0) goes to shadow and swaps at the NEXT frame end.
// - wr_valid while wr_ready=0 is ignored; no data is lost from a prior accepted write.
// - Brightness changes mid-slot take effect at the next slot start only.
// STRUCTURE
// - Package seg_pkg: SEG_BLANK=7'h7F, AN_OFF=8'hFF, 16-entry hex segment table constants, slot FSM state encodings (GUARD/ON/OFF).
// - Sub-module seg_hex_decode: 4-bit nibble -> 7-bit active-low segments, combinational, from the package table.
// - Everything else (prescaler, FSM, buffers, LZ logic) lives in seg_scan_ctrl.
// TESTING (sim params CLK_HZ=3400, REFRESH_HZ=100, GUARD_CYC=2 -> DIV=34, STEP=2)
// 1 Reset/idle: hold rst_n=0 10 cycles, release, no writes -> an=FF, seg=7F, dp=1 forever; frame_done every 272 cycles.
// 2 Write 32'h8765_4321, mask=FF, dp=01, lz=0, brightness=15 -> after swap, each slot: 2 guard cycles an=FF, then 30 cycles an[d]=0,
//   then 2 off; digit 0 shows seg=7'h79 ('1') with dp=0.
// 3 brightness=1 -> 2 on-cycles per slot; brightness=0 -> an stays FF all frame; change mid-slot -> applies next slot only.
// 4 Write 32'h0000_0120, lz=1, mask=FF -> digits 7..3 dark; digits 2,1,0 show '1','2','0'. Write all zeros, lz=1 -> only digit 0 lit ('0').
// 5 Handshake: write A accepted mid-frame (wr_ready->0); write B offered -> ignored; frame end -> A displayed, wr_ready=1.
//   Write on the exact frame-end cycle -> displayed one frame later.
// 6 Assert rst_n=0 mid-ON of digit 4 -> outputs blank in the same cycle; after release, scan restarts at digit 0 with mask=0 (dark).

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants and types for the multiplexed 7-segment scan controller:
// pin idle levels, hex segment table, slot FSM states and the frame record.
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [7:0] AN_OFF    = 8'hFF;

    // Active-low {g,f,e,d,c,b,a}; entry n is the glyph for hex digit n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

    typedef enum logic [1:0] {
        ST_GUARD = 2'd0,
        ST_ON    = 2'd1,
        ST_OFF   = 2'd2
    } slot_state_e;

    typedef struct packed {
        logic [31:0] digits;
        logic [7:0]  dp;
        logic [7:0]  mask;
        logic        lz;
    } frame_t;

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low 7-segment pattern.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// 8-digit common-anode 7-segment scan controller: slot prescaler, guard/PWM
// slot FSM, double-buffered frame with frame-boundary swap, leading-zero blanking.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int REFRESH_HZ = 1000,
    parameter int GUARD_CYC  = 1000      // must be at least 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [31:0] wr_digits,
    input  logic [7:0]  wr_dp,
    input  logic [7:0]  wr_mask,
    input  logic        wr_lz,
    input  logic [3:0]  brightness,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int DIV  = CLK_HZ / REFRESH_HZ;
    localparam int STEP = (DIV - GUARD_CYC) / 16;
    localparam int CW   = $clog2(DIV);

    localparam logic [CW-1:0] LAST_CNT   = CW'(DIV - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYC - 1);

    logic [CW-1:0] slot_cnt;
    logic [2:0]    digit;
    slot_state_e   state, state_nxt;
    logic [3:0]    bright_q;
    logic [3:0]    bright_eff;
    logic [CW-1:0] on_cyc;
    logic          slot_end;
    logic          frame_end;

    frame_t        act;
    frame_t        shadow;
    logic          pending;
    logic          accept;

    logic [7:0]    lz_dark;
    logic [3:0]    cur_nib;
    logic [6:0]    cur_seg;
    logic          lit;

    assign slot_end  = (slot_cnt == LAST_CNT);
    assign frame_end = slot_end && (digit == 3'd7);

    // On the first cycle of a slot the latch is still loading, so use the live input.
    assign bright_eff = (slot_cnt == '0) ? brightness : bright_q;
    assign on_cyc     = CW'(32'(bright_eff) * STEP);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt <= '0;
            digit    <= '0;
            state    <= ST_GUARD;
            bright_q <= '0;
        end else begin
            state <= state_nxt;
            if (slot_cnt == '0)
                bright_q <= brightness;
            if (slot_end) begin
                slot_cnt <= '0;
                digit    <= digit + 3'd1;
            end else begin
                slot_cnt <= slot_cnt + CW'(1);
            end
        end
    end

    // NOTE: state_nxt is defaulted before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_GUARD: if (slot_cnt == GUARD_LAST)
                          state_nxt = (on_cyc == '0) ? ST_OFF : ST_ON;
            ST_ON:    if (slot_cnt == GUARD_LAST + on_cyc)
                          state_nxt = ST_OFF;
            ST_OFF:   if (slot_end)
                          state_nxt = ST_GUARD;
            default:  state_nxt = ST_GUARD;
        endcase
    end

    assign accept   = wr_valid && !pending;
    assign wr_ready = !pending;

    // NOTE: the frame buffers are ordinary flops, not RAM, so they are reset
    // and the display comes up dark with every digit masked off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act     <= '0;
            shadow  <= '0;
            pending <= 1'b0;
        end else if (frame_end && pending) begin
            act     <= shadow;
            pending <= 1'b0;
        end else if (accept) begin
            shadow.digits <= wr_digits;
            shadow.dp     <= wr_dp;
            shadow.mask   <= wr_mask;
            shadow.lz     <= wr_lz;
            pending       <= 1'b1;
        end
    end

    // A digit is LZ-dark while it and every digit above it are zero; digit 0 never is.
    always_comb begin
        logic zero_run;
        lz_dark  = '0;
        zero_run = act.lz;
        for (int i = 7; i >= 1; i--) begin
            zero_run   = zero_run && (act.digits[4*i +: 4] == 4'h0);
            lz_dark[i] = zero_run;
        end
    end

    assign cur_nib = act.digits[{digit, 2'b00} +: 4];

    seg_hex_decode u_hex_decode (
        .nibble (cur_nib),
        .seg    (cur_seg)
    );

    assign lit = (state == ST_ON) && act.mask[digit] && !lz_dark[digit];

    // frame_done shares the pin latency so it lines up with the last digit-7 cycle seen on the pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an         <= AN_OFF;
            seg        <= SEG_BLANK;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            an         <= lit ? ~(8'h01 << digit) : AN_OFF;
            seg        <= lit ? cur_seg : SEG_BLANK;
            dp         <= lit ? ~act.dp[digit] : 1'b1;
            frame_done <= frame_end;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomised self-checking bench for seg_scan_ctrl against a cycle-index
// reference model (slot position and digit derived arithmetically).
module tb_seg_scan_ctrl;

    localparam int CLK_HZ     = 3400;
    localparam int REFRESH_HZ = 100;
    localparam int GUARD_CYC  = 2;
    localparam int DIV        = CLK_HZ / REFRESH_HZ;
    localparam int STEP       = (DIV - GUARD_CYC) / 16;
    localparam int FRAME      = 8 * DIV;

    typedef struct packed {
        logic [31:0] digits;
        logic [7:0]  dp;
        logic [7:0]  mask;
        logic        lz;
    } frame_s;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [31:0] wr_digits = '0;
    logic [7:0]  wr_dp = '0;
    logic [7:0]  wr_mask = '0;
    logic        wr_lz = 1'b0;
    logic [3:0]  brightness = '0;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .CLK_HZ     (CLK_HZ),
        .REFRESH_HZ (REFRESH_HZ),
        .GUARD_CYC  (GUARD_CYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_digits  (wr_digits),
        .wr_dp      (wr_dp),
        .wr_mask    (wr_mask),
        .wr_lz      (wr_lz),
        .brightness (brightness),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: k = cycles since reset release
    int     k = 0;
    int     m_bright = 0;
    frame_s m_act = '0;
    frame_s m_shadow = '0;
    bit     m_pending = 1'b0;

    // Driver state
    bit         drv_valid = 1'b0;
    frame_s     drv_frame = '0;
    logic [3:0] drv_bright = 4'd15;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [15:0] model_pins(input int pos, input int dig);
        logic [3:0] nib;
        bit         on_win, lz_blank;
        nib      = m_act.digits[4*dig +: 4];
        on_win   = (pos >= GUARD_CYC) && (pos < GUARD_CYC + m_bright * STEP);
        lz_blank = m_act.lz && (dig != 0) && ((m_act.digits >> (4*dig)) == 32'd0);
        if (!(on_win && m_act.mask[dig] && !lz_blank))
            return 16'hFFFF;
        return {~(8'd1 << dig), hex_tab[nib], ~m_act.dp[dig]};
    endfunction

    task automatic model_reset();
        k = 0;
        m_bright = 0;
        m_act = '0;
        m_shadow = '0;
        m_pending = 1'b0;
    endtask

    // One clock: drive inputs at negedge, advance model, compare #1 after posedge.
    task automatic step();
        logic [15:0] exp_pins;
        bit          exp_fd;
        int          pos, dig;
        @(negedge clk);
        wr_valid   = drv_valid;
        wr_digits  = drv_frame.digits;
        wr_dp      = drv_frame.dp;
        wr_mask    = drv_frame.mask;
        wr_lz      = drv_frame.lz;
        brightness = drv_bright;
        pos = k % DIV;
        dig = (k / DIV) % 8;
        if (pos == 0) m_bright = int'(drv_bright);
        exp_pins = model_pins(pos, dig);
        exp_fd   = (k % FRAME) == FRAME - 1;
        if (exp_fd && m_pending) begin
            m_act = m_shadow;
            m_pending = 1'b0;
        end else if (drv_valid && !m_pending) begin
            m_shadow = drv_frame;
            m_pending = 1'b1;
        end
        @(posedge clk);
        #1;
        check("pins", 32'({an, seg, dp}), 32'(exp_pins));
        check("frame_done", 32'(frame_done), 32'(exp_fd));
        check("wr_ready", 32'(wr_ready), 32'(!m_pending));
        k++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic write_frame(input logic [31:0] digits, input logic [7:0] dpv,
                               input logic [7:0] mask, input logic lz);
        drv_frame = '{digits: digits, dp: dpv, mask: mask, lz: lz};
        drv_valid = 1'b1;
        step();
        drv_valid = 1'b0;
    endtask

    function automatic frame_s rand_frame();
        frame_s f;
        for (int i = 0; i < 8; i++)
            f.digits[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        f.dp   = 8'($urandom);
        f.mask = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
        f.lz   = 1'($urandom);
        return f;
    endfunction

    initial begin
        // Reset / idle
        repeat (10) @(posedge clk);
        #1;
        check("rst_pins", 32'({an, seg, dp}), 32'h0000_FFFF);
        check("rst_wr_ready", 32'(wr_ready), 32'd1);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        rst_n = 1'b1;
        model_reset();
        run(600);

        // Full-brightness frame, digit 0 shows '1' with its point lit
        write_frame(32'h8765_4321, 8'h01, 8'hFF, 1'b0);
        run(2 * FRAME);
        for (int i = 0; i < FRAME && (k % FRAME) != GUARD_CYC + 1; i++) step();
        check("digit0_an", 32'(an), 32'h0000_00FE);
        check("digit0_seg", 32'(seg), 32'h0000_0079);
        check("digit0_dp", 32'(dp), 32'd0);

        // Brightness extremes, then changes on arbitrary cycles
        drv_bright = 4'd1;
        run(FRAME);
        drv_bright = 4'd0;
        run(FRAME);
        for (int i = 0; i < 2 * FRAME; i++) begin
            drv_bright = 4'($urandom_range(0, 15));
            step();
        end

        // Leading-zero blanking
        drv_bright = 4'd15;
        write_frame(32'h0000_0120, 8'h00, 8'hFF, 1'b1);
        run(2 * FRAME);
        write_frame(32'h0000_0000, 8'hFF, 8'hFF, 1'b1);
        run(2 * FRAME);

        // Handshake: A accepted, B offered while busy and ignored
        run(FRAME / 2);
        write_frame(32'hAAAA_5555, 8'h0F, 8'hFF, 1'b0);
        drv_frame = '{digits: 32'hBBBB_CCCC, dp: 8'hF0, mask: 8'hFF, lz: 1'b0};
        drv_valid = 1'b1;
        run(60);
        drv_valid = 1'b0;
        run(2 * FRAME);

        // Write landing exactly on the frame-end cycle
        for (int i = 0; i < 2 * FRAME && ((k % FRAME) != FRAME - 1 || m_pending); i++) step();
        check("at_frame_end", 32'((k % FRAME) == FRAME - 1 && !m_pending), 32'd1);
        write_frame(32'hDEAD_BEEF, 8'hA5, 8'hFF, 1'b0);
        run(2 * FRAME);

        // Async reset in the middle of digit 4's ON window
        write_frame(32'h8765_4321, 8'h10, 8'hFF, 1'b0);
        run(2 * FRAME);
        for (int i = 0; i < FRAME && (k % FRAME) != 4 * DIV + GUARD_CYC + 4; i++) step();
        check("pre_reset_an", 32'(an), 32'h0000_00EF);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst_an", 32'(an), 32'h0000_00FF);
        check("async_rst_seg", 32'(seg), 32'h0000_007F);
        check("async_rst_dp", 32'(dp), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        run(FRAME);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            drv_valid = ($urandom_range(0, 19) == 0);
            if (drv_valid) drv_frame = rand_frame();
            if ($urandom_range(0, 9) == 0) drv_bright = 4'($urandom_range(0, 15));
            step();
        end
        drv_valid = 1'b0;
        run(FRAME);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
